// File: rtl/run_launcher.sv
// Run launcher: puts a processor core through reset and start, waits for the
// core to finish or time out, then reads a 4-byte result from data memory.
module run_launcher #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 1023,
    parameter logic [7:0]  RD_BASE     = 8'h04
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Go,
    output logic        Busy,
    output logic        CoreReset,
    output logic        CoreStart,
    input  logic        CoreAck,
    output logic [7:0]  DmAddr,
    input  logic [7:0]  DmRdData,
    output logic [31:0] Result,
    output logic        Done,
    output logic        TimedOut
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned STEP_W   = 4;
    localparam int unsigned RD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        SETTLE = 3'd4,
        READ   = 3'd5,
        FIN    = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;
    logic              go_accept;

    logic [23:0]       shadow;

    logic              busy_d;
    logic              core_reset_d;
    logic              core_start_d;
    logic              done_d;
    logic [7:0]        dm_addr_d;

    assign cnt_inc   = cnt + 1'b1;
    assign go_accept = (state == IDLE) && Go;

    // State register plus the phase step and RUN cycle counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            step  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; CoreAck only matters while in RUN
    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        cnt_nxt     = cnt;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (Go) begin
                    state_nxt = INIT;
                    step_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            INIT: begin
                if (step == STEP_W'(INIT_CYCLES - 1)) begin
                    state_nxt = LAUNCH;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + 1'b1;
                end
            end
            LAUNCH: begin
                state_nxt = RUN;
            end
            RUN: begin
                cnt_nxt = cnt_inc;
                // an ack on the final allowed cycle still counts as success
                if (CoreAck) begin
                    state_nxt = SETTLE;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_nxt   = FIN;
                    timeout_hit = 1'b1;
                end
            end
            SETTLE: begin
                state_nxt = READ;
                step_nxt  = '0;
            end
            READ: begin
                // four address cycles plus one trailing data-capture cycle
                if (step == STEP_W'(RD_BYTES)) begin
                    state_nxt = FIN;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step + 1'b1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, registered below
    always_comb begin
        busy_d       = (state_nxt != IDLE);
        core_start_d = (state_nxt == INIT) || (state_nxt == LAUNCH);
        core_reset_d = CoreReset;
        done_d       = (state_nxt == FIN);
        dm_addr_d    = 8'h00;
        if (state_nxt == INIT) begin
            core_reset_d = 1'b1;
        end else if (state_nxt == LAUNCH) begin
            core_reset_d = 1'b0;
        end
        if ((state_nxt == READ) && (step_nxt < STEP_W'(RD_BYTES))) begin
            dm_addr_d = RD_BASE + 8'(step_nxt);
        end
    end

    // Registered outputs, result shadow and timeout flag
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Busy      <= 1'b0;
            CoreReset <= 1'b1;
            CoreStart <= 1'b0;
            DmAddr    <= 8'h00;
            Done      <= 1'b0;
            TimedOut  <= 1'b0;
            Result    <= 32'h0;
            shadow    <= 24'h0;
        end else begin
            Busy      <= busy_d;
            CoreReset <= core_reset_d;
            CoreStart <= core_start_d;
            DmAddr    <= dm_addr_d;
            Done      <= done_d;
            if (go_accept) begin
                TimedOut <= 1'b0;
            end else if (timeout_hit) begin
                TimedOut <= 1'b1;
            end
            // data lags the address by one cycle; last byte lands with the word
            if (state == READ) begin
                case (step)
                    STEP_W'(1): shadow[23:16] <= DmRdData;
                    STEP_W'(2): shadow[15:8]  <= DmRdData;
                    STEP_W'(3): shadow[7:0]   <= DmRdData;
                    STEP_W'(4): Result        <= {shadow, DmRdData};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_run_launcher.sv
// Randomised self-checking bench for run_launcher: two instances with
// different parameters, a registered data-memory model and a timing model.
module tb_run_launcher;

    localparam int         IC0 = 2;
    localparam int         IC1 = 3;
    localparam int         TO1 = 10;
    localparam logic [7:0] B0  = 8'h04;
    localparam logic [7:0] B1  = 8'hFE;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [1:0]        go;
    logic [1:0]        ack;
    logic [1:0]        busy;
    logic [1:0]        core_reset;
    logic [1:0]        core_start;
    logic [1:0]        done;
    logic [1:0]        timed_out;
    logic [1:0][7:0]   dm_addr;
    logic [1:0][7:0]   rd;
    logic [1:0][31:0]  result;
    logic [7:0]        mem [2][256];

    int checks = 0;
    int errors = 0;

    logic [31:0] model_res [2];
    bit          go_plan  [256];
    bit          ack_plan [256];
    int          done_q [$];
    logic [31:0] res_q  [$];
    logic        to_q   [$];
    logic [7:0]  addr_t [$];
    logic        busy_t [$];
    logic        cr_t   [$];
    logic        cs_t   [$];

    always #5 Clk = ~Clk;

    run_launcher u_a (
        .Clk(Clk), .Reset(Reset), .Go(go[0]), .Busy(busy[0]),
        .CoreReset(core_reset[0]), .CoreStart(core_start[0]), .CoreAck(ack[0]),
        .DmAddr(dm_addr[0]), .DmRdData(rd[0]), .Result(result[0]),
        .Done(done[0]), .TimedOut(timed_out[0])
    );

    run_launcher #(.INIT_CYCLES(IC1), .TIMEOUT(TO1), .RD_BASE(B1)) u_b (
        .Clk(Clk), .Reset(Reset), .Go(go[1]), .Busy(busy[1]),
        .CoreReset(core_reset[1]), .CoreStart(core_start[1]), .CoreAck(ack[1]),
        .DmAddr(dm_addr[1]), .DmRdData(rd[1]), .Result(result[1]),
        .Done(done[1]), .TimedOut(timed_out[1])
    );

    // synchronous-read data memory: data valid one cycle after address
    always @(posedge Clk) begin
        rd[0] <= mem[0][dm_addr[0]];
        rd[1] <= mem[1][dm_addr[1]];
    end

    function automatic int ic_of(input int i);
        return (i == 0) ? IC0 : IC1;
    endfunction

    function automatic logic [7:0] base_of(input int i);
        return (i == 0) ? B0 : B1;
    endfunction

    // expected result word: four bytes from base upward, first byte in MSBs
    function automatic logic [31:0] exp_word(input int i);
        logic [7:0]  a;
        logic [31:0] w;
        a = base_of(i);
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w = {w[23:0], mem[i][a]};
            a = a + 8'd1;
        end
        return w;
    endfunction

    // Go-to-Done latency when the core acks on RUN cycle n
    function automatic int exp_lat(input int i, input int n);
        return ic_of(i) + 1 + n + 1 + 5 + 1;
    endfunction

    task automatic clear_plans();
        for (int c = 0; c < 256; c++) begin
            go_plan[c]  = 1'b0;
            ack_plan[c] = 1'b0;
        end
    endtask

    // schedule a success run: Go on cycle 0, ack on RUN cycle n
    task automatic plan_run(input int i, input int start, input int n);
        go_plan[start] = 1'b1;
        ack_plan[start + ic_of(i) + 1 + n] = 1'b1;
    endtask

    task automatic randomize_mem(input int i);
        for (int a = 0; a < 256; a++) mem[i][a] = 8'($urandom);
    endtask

    // drive plans cycle by cycle on instance i and record what it shows
    task automatic run_cycles(input int i, input int ncyc);
        done_q.delete(); res_q.delete(); to_q.delete();
        addr_t.delete(); busy_t.delete(); cr_t.delete(); cs_t.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Clk);
            addr_t.push_back(dm_addr[i]);
            busy_t.push_back(busy[i]);
            cr_t.push_back(core_reset[i]);
            cs_t.push_back(core_start[i]);
            if (done[i]) begin
                done_q.push_back(c);
                res_q.push_back(result[i]);
                to_q.push_back(timed_out[i]);
            end
            go[i]  = go_plan[c];
            ack[i] = ack_plan[c];
        end
        go[i]  = 1'b0;
        ack[i] = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        go    = '0;
        ack   = '0;
        #12;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy[i], core_reset[i], core_start[i], done[i], timed_out[i]} !== 5'b01000) begin
                errors++;
                $display("FAIL reset_ctrl inst %0d got %b exp 01000", i,
                         {busy[i], core_reset[i], core_start[i], done[i], timed_out[i]});
            end
            checks++;
            if ({dm_addr[i], result[i]} !== 40'h0) begin
                errors++;
                $display("FAIL reset_data inst %0d addr %h result %h exp 0", i, dm_addr[i], result[i]);
            end
            model_res[i] = 32'h0;
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        int bad_busy;
        int bad_core;
        int bad_addr;
        int rd0;
        logic [7:0] exp_a;
        logic exp_cr;
        logic exp_cs;
        randomize_mem(0);
        mem[0][4] = 8'h12; mem[0][5] = 8'h34; mem[0][6] = 8'h56; mem[0][7] = 8'h78;
        clear_plans();
        plan_run(0, 0, 20);
        go_plan[10] = 1'b1;
        lat = exp_lat(0, 20);
        run_cycles(0, lat + 4);
        checks++;
        if (done_q.size() != 1 || done_q[0] != 30) begin
            errors++;
            $display("FAIL basic_latency pulses %0d first %0d exp one at 30", done_q.size(),
                     done_q.size() > 0 ? done_q[0] : -1);
        end
        checks++;
        if (res_q.size() < 1 || res_q[0] !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_result got %h exp 12345678", res_q.size() > 0 ? res_q[0] : 32'hx);
        end
        checks++;
        if (to_q.size() < 1 || to_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_timedout got %b exp 0", to_q.size() > 0 ? to_q[0] : 1'bx);
        end
        bad_busy = 0; bad_core = 0; bad_addr = 0;
        rd0 = IC0 + 20 + 3;
        for (int c = 0; c < lat + 4; c++) begin
            if (busy_t[c] !== ((c >= 1) && (c <= lat))) bad_busy++;
            exp_a = 8'h00;
            if ((c >= rd0) && (c < rd0 + 4)) exp_a = B0 + 8'(c - rd0);
            if (addr_t[c] !== exp_a) bad_addr++;
            if (c <= IC0 + 1 + 20) begin
                exp_cr = (c <= IC0);
                exp_cs = (c >= 1) && (c <= IC0 + 1);
                if (cr_t[c] !== exp_cr || cs_t[c] !== exp_cs) bad_core++;
            end
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL basic_busy got %0d bad cycles exp 0", bad_busy);
        end
        checks++;
        if (bad_core != 0) begin
            errors++;
            $display("FAIL basic_core_ctrl got %0d bad cycles exp 0", bad_core);
        end
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("FAIL basic_dmaddr got %0d bad cycles exp 0", bad_addr);
        end
        model_res[0] = 32'h12345678;
    endtask

    task automatic test_random();
        int i;
        int n;
        logic [31:0] w;
        for (int it = 0; it < 6; it++) begin
            i = it % 2;
            n = (i == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, TO1));
            randomize_mem(i);
            w = exp_word(i);
            clear_plans();
            plan_run(i, 0, n);
            run_cycles(i, exp_lat(i, n) + 3);
            checks++;
            if (done_q.size() != 1 || done_q[0] != exp_lat(i, n)) begin
                errors++;
                $display("FAIL rand_latency inst %0d n %0d pulses %0d first %0d exp %0d", i, n,
                         done_q.size(), done_q.size() > 0 ? done_q[0] : -1, exp_lat(i, n));
            end
            checks++;
            if (res_q.size() < 1 || res_q[0] !== w || to_q[0] !== 1'b0) begin
                errors++;
                $display("FAIL rand_result inst %0d got %h exp %h", i,
                         res_q.size() > 0 ? res_q[0] : 32'hx, w);
            end
            model_res[i] = w;
        end
    endtask

    task automatic test_timeout();
        int lat;
        lat = IC1 + 1 + TO1 + 1;
        randomize_mem(1);
        clear_plans();
        go_plan[0] = 1'b1;
        run_cycles(1, lat + 4);
        checks++;
        if (done_q.size() != 1 || done_q[0] != lat) begin
            errors++;
            $display("FAIL timeout_latency pulses %0d first %0d exp one at %0d", done_q.size(),
                     done_q.size() > 0 ? done_q[0] : -1, lat);
        end
        checks++;
        if (to_q.size() < 1 || to_q[0] !== 1'b1 || res_q[0] !== model_res[1]) begin
            errors++;
            $display("FAIL timeout_flag_result to %b result %h exp 1 %h",
                     to_q.size() > 0 ? to_q[0] : 1'bx, res_q.size() > 0 ? res_q[0] : 32'hx, model_res[1]);
        end
        @(negedge Clk);
        checks++;
        if (timed_out[1] !== 1'b1 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold timedout %b busy %b exp 1 0", timed_out[1], busy[1]);
        end
    endtask

    task automatic test_boundary_ack();
        logic [31:0] w;
        randomize_mem(1);
        w = exp_word(1);
        clear_plans();
        plan_run(1, 0, TO1);
        run_cycles(1, exp_lat(1, TO1) + 3);
        checks++;
        if (done_q.size() != 1 || done_q[0] != exp_lat(1, TO1) || to_q[0] !== 1'b0 || res_q[0] !== w) begin
            errors++;
            $display("FAIL boundary_ack pulses %0d at %0d to %b result %h exp one at %0d 0 %h",
                     done_q.size(), done_q.size() > 0 ? done_q[0] : -1,
                     to_q.size() > 0 ? to_q[0] : 1'bx, res_q.size() > 0 ? res_q[0] : 32'hx,
                     exp_lat(1, TO1), w);
        end
        model_res[1] = w;
    endtask

    task automatic test_early_ack();
        logic [31:0] w;
        randomize_mem(0);
        w = exp_word(0);
        clear_plans();
        for (int c = 0; c <= IC0 + 1; c++) ack_plan[c] = 1'b1;
        plan_run(0, 0, 5);
        run_cycles(0, exp_lat(0, 5) + 3);
        checks++;
        if (done_q.size() != 1 || done_q[0] != exp_lat(0, 5) || res_q[0] !== w) begin
            errors++;
            $display("FAIL early_ack pulses %0d at %0d result %h exp one at %0d %h",
                     done_q.size(), done_q.size() > 0 ? done_q[0] : -1,
                     res_q.size() > 0 ? res_q[0] : 32'hx, exp_lat(0, 5), w);
        end
        model_res[0] = w;
    endtask

    task automatic test_wrap();
        int rd0;
        logic [31:0] seen;
        randomize_mem(1);
        mem[1][8'hFE] = 8'hAA; mem[1][8'hFF] = 8'hBB; mem[1][8'h00] = 8'hCC; mem[1][8'h01] = 8'hDD;
        clear_plans();
        plan_run(1, 0, 4);
        run_cycles(1, exp_lat(1, 4) + 3);
        checks++;
        if (res_q.size() < 1 || res_q[0] !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL wrap_result got %h exp aabbccdd", res_q.size() > 0 ? res_q[0] : 32'hx);
        end
        rd0 = IC1 + 4 + 3;
        seen = {addr_t[rd0], addr_t[rd0 + 1], addr_t[rd0 + 2], addr_t[rd0 + 3]};
        checks++;
        if (seen !== 32'hFEFF0001) begin
            errors++;
            $display("FAIL wrap_addr got %h exp feff0001", seen);
        end
        model_res[1] = 32'hAABBCCDD;
    endtask

    task automatic test_reset_mid();
        int spurious;
        logic [31:0] w;
        randomize_mem(0);
        for (int c = 0; c <= IC0 + 10 + 4; c++) begin
            @(negedge Clk);
            go[0]  = (c == 0);
            ack[0] = (c == IC0 + 1 + 10);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if ({busy[0], core_reset[0], core_start[0], done[0], timed_out[0]} !== 5'b01000 ||
            dm_addr[0] !== 8'h00 || result[0] !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs ctrl %b addr %h result %h exp 01000 00 0",
                     {busy[0], core_reset[0], core_start[0], done[0], timed_out[0]}, dm_addr[0], result[0]);
        end
        model_res[0] = 32'h0;
        model_res[1] = 32'h0;
        @(negedge Clk);
        Reset  = 1'b1;
        go[0]  = 1'b0;
        ack[0] = 1'b0;
        spurious = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midreset_quiet got %0d active cycles exp 0", spurious);
        end
        w = exp_word(0);
        clear_plans();
        plan_run(0, 0, 7);
        run_cycles(0, exp_lat(0, 7) + 3);
        checks++;
        if (done_q.size() != 1 || done_q[0] != exp_lat(0, 7) || res_q[0] !== w) begin
            errors++;
            $display("FAIL midreset_rerun pulses %0d at %0d result %h exp one at %0d %h",
                     done_q.size(), done_q.size() > 0 ? done_q[0] : -1,
                     res_q.size() > 0 ? res_q[0] : 32'hx, exp_lat(0, 7), w);
        end
        model_res[0] = w;
    endtask

    task automatic test_back_to_back();
        int l1;
        int l2;
        logic [31:0] w;
        randomize_mem(0);
        w = exp_word(0);
        l1 = exp_lat(0, 6);
        l2 = exp_lat(0, 9);
        clear_plans();
        for (int c = 0; c <= l1 + 1 + l2; c++) go_plan[c] = 1'b1;
        ack_plan[IC0 + 1 + 6] = 1'b1;
        ack_plan[l1 + 1 + IC0 + 1 + 9] = 1'b1;
        run_cycles(0, l1 + 1 + l2 + 3);
        checks++;
        if (done_q.size() != 2 || done_q[0] != l1 || done_q[1] != l1 + 1 + l2) begin
            errors++;
            $display("FAIL b2b_done pulses %0d first %0d exp 2 at %0d and %0d", done_q.size(),
                     done_q.size() > 0 ? done_q[0] : -1, l1, l1 + 1 + l2);
        end
        checks++;
        if ({busy_t[l1], busy_t[l1 + 1], busy_t[l1 + 2]} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_idle_gap got %b exp 101", {busy_t[l1], busy_t[l1 + 1], busy_t[l1 + 2]});
        end
        checks++;
        if (res_q.size() != 2 || res_q[0] !== w || res_q[1] !== w) begin
            errors++;
            $display("FAIL b2b_result got %h exp %h", res_q.size() > 0 ? res_q[0] : 32'hx, w);
        end
        model_res[0] = w;
    endtask

    initial begin
        Reset = 1'b0;
        go    = '0;
        ack   = '0;
        for (int i = 0; i < 2; i++) begin
            randomize_mem(i);
            model_res[i] = 32'h0;
        end
        test_reset();
        test_basic();
        test_random();
        test_timeout();
        test_boundary_ack();
        test_early_ack();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/run_launcher.md
RUN_LAUNCHER -- requirements
Module: run_launcher

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 2, meaning cycles CoreReset is held high before launch (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning max RUN-state cycles before abort (legal range 1..65535).
REQ-003 SHALL have parameter RD_BASE, default 8'h04, meaning first data-memory address of the 4-byte result.
REQ-004 SHALL have port Clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Go  input  1  host run request, sampled only in IDLE.
REQ-007 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port CoreReset  output  1  reset drive to the processor core.
REQ-009 SHALL have port CoreStart  output  1  start request to the processor core.
REQ-010 SHALL have port CoreAck  input  1  core done flag, level, synchronous to Clk.
REQ-011 SHALL have port DmAddr  output  8  data-memory read address.
REQ-012 SHALL have port DmRdData  input  8  data-memory read data, valid one cycle after DmAddr.
REQ-013 SHALL have port Result  output  32  assembled result word.
REQ-014 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port TimedOut  output  1  run aborted on timeout; held until next accepted Go.

Function
REQ-016 SHALL implement states IDLE, INIT, LAUNCH, RUN, SETTLE, READ, FIN.
REQ-017 IDLE: Go=1 SHALL move to INIT next cycle, clear TimedOut and the cycle counter; Go=0 stays.
REQ-018 INIT: CoreReset=1 and CoreStart=1 for exactly INIT_CYCLES cycles, then LAUNCH.
REQ-019 LAUNCH: CoreReset=0, CoreStart=1 for exactly one cycle, then RUN.
REQ-020 RUN: CoreReset=0, CoreStart=0; 16-bit counter increments each cycle; CoreAck=1 moves to SETTLE.
REQ-021 RUN: counter reaching TIMEOUT with CoreAck=0 SHALL set TimedOut=1 and move to FIN; Result SHALL keep its prior value.
REQ-022 CoreAck=1 in the same cycle the counter reaches TIMEOUT SHALL be treated as success (SETTLE, TimedOut stays 0).
REQ-023 CoreAck SHALL be ignored in IDLE, INIT and LAUNCH.
REQ-024 SETTLE: one idle cycle, then READ.
REQ-025 READ: DmAddr SHALL present RD_BASE, +1, +2, +3 on 4 consecutive cycles (8-bit wrap-around, e.g. RD_BASE=8'hFE reads FE, FF, 00, 01); data captured one cycle later, 5 READ cycles total, then FIN.
REQ-026 Packing: byte from RD_BASE -> Result[31:24], +1 -> [23:16], +2 -> [15:8], +3 -> [7:0].
REQ-027 Result SHALL update only in FIN, atomically from a shadow register; it never shows a partial word.
REQ-028 FIN: Done=1 for one cycle, then IDLE; Done also pulses on timeout.
REQ-029 Go asserted while Busy=1 SHALL be ignored and not queued.
REQ-030 DmAddr SHALL read 8'h00 outside READ.
REQ-031 Go-to-Done latency on success SHALL be INIT_CYCLES + 1 + N + 1 + 5 + 1 cycles, where N is RUN cycles up to and including the CoreAck cycle.

Reset
REQ-032 Reset=0 SHALL immediately and asynchronously force IDLE, Busy=0, CoreReset=1, CoreStart=0, DmAddr=8'h00, Result=32'h0, Done=0, TimedOut=0, counter=0.
REQ-033 Reset asserted mid-run (any state) SHALL abort with no Done pulse and no Result update.
REQ-034 After Reset deasserts, CoreReset SHALL stay 1 until the next INIT completes.

Verification
REQ-035 Go pulse, core model acks after 20 RUN cycles, DM[4..7]=12,34,56,78 -> Result=32'h12345678, Done one pulse at latency 2+1+20+1+5+1=30, TimedOut=0.
REQ-036 TIMEOUT=10, CoreAck never asserted -> TimedOut=1 and Done pulse after exactly 10 RUN cycles; Result unchanged from prior run.
REQ-037 CoreAck asserted during INIT/LAUNCH then dropped -> still waits in RUN; a later ack after 5 cycles completes normally.
REQ-038 RD_BASE=8'hFE, DM[FE,FF,00,01]=AA,BB,CC,DD -> Result=32'hAABBCCDD.
REQ-039 Reset low during READ -> outputs at reset values at once, no Done; subsequent Go completes a full run correctly.
REQ-040 Go held high continuously -> back-to-back runs, each separated by one IDLE cycle, exactly one Done per run.
